// File: rtl/fusion_unit_pipe.sv
// Bit Fusion processing element: 2x2-bit bricks fused per operand width into a
// dot product, three-stage pipeline with in-unit temporal accumulation.
module fusion_unit_pipe #(
  parameter int MAX_BITS = 8,
  parameter int ACC_W    = 32,
  parameter int WCODE_W  = $clog2($clog2(MAX_BITS))
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [MAX_BITS*MAX_BITS/2-1:0]   in,
  input  logic [MAX_BITS*MAX_BITS/2-1:0]   weight,
  input  logic [WCODE_W-1:0]               in_width,
  input  logic [WCODE_W-1:0]               weight_width,
  input  logic                             s_in,
  input  logic                             s_weight,
  input  logic                             acc_first,
  input  logic                             acc_last,
  output logic [ACC_W-1:0]                 psum_fwd,
  output logic                             psum_valid,
  output logic                             acc_ovf
);

  localparam int          OP_W     = MAX_BITS * MAX_BITS / 2;
  localparam int          NBRICK   = (MAX_BITS / 2) * (MAX_BITS / 2);
  localparam int          DOT_W    = 2 * MAX_BITS + 1;
  localparam int unsigned MAX_CODE = $clog2(MAX_BITS) - 1;

  if (ACC_W < 2 * MAX_BITS + 1) begin : g_acc_w_check
    $error("fusion_unit_pipe: ACC_W must be at least 2*MAX_BITS+1");
  end

  function automatic int unsigned decode_code(input logic [WCODE_W-1:0] c);
    int unsigned v;
    v = int'(c);
    if (v > MAX_CODE) v = MAX_CODE;
    return v;
  endfunction

  // Brick k belongs to lane k/(na*nb); within the lane, bricks walk the input
  // crumbs fastest, so the shift is 2*(input crumb + weight crumb).
  function automatic logic signed [DOT_W-1:0] brick_term(
    input int unsigned     k,
    input int unsigned     ca,
    input int unsigned     cb,
    input logic [OP_W-1:0] x,
    input logic [OP_W-1:0] w,
    input logic            sx,
    input logic            sw
  );
    int unsigned             na, nb, lane, r, j, m, xi, wi;
    logic [1:0]              cx, cw;
    logic signed [2:0]       bx, bw;
    logic signed [5:0]       p;
    logic signed [DOT_W-1:0] t;
    na   = 1 << ca;
    nb   = 1 << cb;
    lane = k >> (ca + cb);
    r    = k & ((1 << (ca + cb)) - 1);
    j    = r & (na - 1);
    m    = r >> ca;
    xi   = (lane << ca) + j;
    wi   = (lane << cb) + m;
    cx   = 2'(x >> (2 * xi));
    cw   = 2'(w >> (2 * wi));
    bx   = {sx && (j == na - 1) && cx[1], cx};
    bw   = {sw && (m == nb - 1) && cw[1], cw};
    p    = bx * bw;
    t    = DOT_W'(p);
    return t <<< (2 * (j + m));
  endfunction

  logic                     v1, sx1, sw1, f1, l1;
  logic [OP_W-1:0]          x1, w1;
  logic [WCODE_W-1:0]       cx1, cw1;
  logic                     v2, f2, l2;
  logic signed [DOT_W-1:0]  dot_c, dot2;
  logic signed [ACC_W-1:0]  acc, acc_next, dot_ext;
  logic signed [ACC_W:0]    sum_x;
  logic                     ovf_next;
  int unsigned              ca1, cb1;

  always_comb begin
    ca1   = decode_code(cx1);
    cb1   = decode_code(cw1);
    dot_c = '0;
    for (int unsigned k = 0; k < NBRICK; k++) begin
      dot_c = dot_c + brick_term(k, ca1, cb1, x1, w1, sx1, sw1);
    end
  end

  // Overflow is judged on the exact sum, one bit wider than the accumulator.
  always_comb begin
    dot_ext = ACC_W'(dot2);
    sum_x   = (ACC_W + 1)'(acc) + (ACC_W + 1)'(dot2);
    if (f2) begin
      acc_next = dot_ext;
      ovf_next = 1'b0;
    end else begin
      acc_next = sum_x[ACC_W-1:0];
      ovf_next = acc_ovf | (sum_x[ACC_W] ^ sum_x[ACC_W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      x1         <= '0;
      w1         <= '0;
      cx1        <= '0;
      cw1        <= '0;
      sx1        <= 1'b0;
      sw1        <= 1'b0;
      f1         <= 1'b0;
      l1         <= 1'b0;
      v2         <= 1'b0;
      dot2       <= '0;
      f2         <= 1'b0;
      l2         <= 1'b0;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      psum_fwd   <= '0;
      psum_valid <= 1'b0;
    end else begin
      v1         <= in_valid;
      x1         <= in;
      w1         <= weight;
      cx1        <= in_width;
      cw1        <= weight_width;
      sx1        <= s_in;
      sw1        <= s_weight;
      f1         <= acc_first;
      l1         <= acc_last;
      v2         <= v1;
      dot2       <= dot_c;
      f2         <= f1;
      l2         <= l1;
      psum_valid <= v2 && l2;
      if (v2) begin
        acc     <= acc_next;
        acc_ovf <= ovf_next;
        if (l2) psum_fwd <= acc_next;
      end
    end
  end

endmodule

// File: doc/fusion_unit_pipe.md
Name: fusion_unit_pipe

Overview:
- Parametrised, pipelined Bit Fusion processing element built from (MAX_BITS/2)^2 2x2-bit bitbricks.
- Each cycle it fuses the bricks into 64/(a*b) products (a = input width, b = weight width; both powers of two, 2..MAX_BITS) and sums them into a dot product.
- Across a burst of valid cycles, the dot products are accumulated into a wide accumulator.
- The block sits in the systolic array where the single-cycle 4-brick fusion unit sat today. It adds 8-bit operands, in-unit temporal accumulation, valid tracking and overflow flagging.

Parameters:
- MAX_BITS, 8, maximum operand width; power of two, at least 4. Brick count is (MAX_BITS/2)^2.
- ACC_W, 32, accumulator and output width. Elaboration-time error if ACC_W < 2*MAX_BITS+1.
- WCODE_W, $clog2($clog2(MAX_BITS)), width of the width-select codes (2 for MAX_BITS=8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in  in  MAX_BITS*MAX_BITS/2  packed input values, LSB-first, a bits each.
- weight  in  MAX_BITS*MAX_BITS/2  packed weight values, LSB-first, b bits each.
- in_width  in  WCODE_W  log2(a)-1 (0: 2b, 1: 4b, 2: 8b). Codes above the maximum are treated as MAX_BITS.
- weight_width  in  WCODE_W  log2(b)-1, same encoding.
- s_in  in  1  input values are two's complement.
- s_weight  in  1  weight values are two's complement.
- acc_first  in  1  this beat starts a new accumulation.
- acc_last  in  1  this beat ends the accumulation.
- psum_fwd  out  ACC_W  accumulated result, signed.
- psum_valid  out  1  one-cycle strobe; psum_fwd is valid.
- acc_ovf  out  1  sticky overflow for the current accumulation; valid with psum_valid.

Behaviour:
- Reset (synchronous): all pipeline valids, accumulator, psum_fwd, psum_valid and acc_ovf go to 0. In-flight beats are discarded, including a partial accumulation; no output is produced for them.
- Operand decode:
  - P = MAX_BITS^2/(a*b) products.
  - Input value i = in[i*a +: a], i = 0..P-1.
  - Weight value i = weight[i*b +: b].
  - Bits above P*a (resp. P*b) are ignored.
  - Signedness applies only to the top brick of each value. Lower bricks are always unsigned.
- Dot product:
  - Sum over i of in_i*weight_i.
  - Exact in DOT_W = 2*MAX_BITS+1 signed bits.
  - Built from brick products shifted per a brick shift table indexed by (a, b, brick position).
- Pipeline, full throughput, one beat per cycle, no backpressure:
  - S1: register in, weight, width codes, sign bits, acc_first, acc_last, in_valid.
  - S2: brick multiply, shift and adder tree; register dot and control.
  - S3: accumulate.
    - If first: acc <- sext(dot).
    - Else: acc <- acc + sext(dot), wrapping at ACC_W.
- Latency: a beat sampled at edge k updates acc at edge k+2.
  - If that beat had acc_last, psum_valid is high for exactly the cycle after edge k+2, with psum_fwd = new acc.
  - psum_fwd holds its value between strobes.
- acc_ovf:
  - Cleared by a first beat.
  - Set when the exact signed sum is not representable in ACC_W.
  - Sticky until the next first beat.
- in_valid low: bubble. acc, acc_ovf and outputs are unchanged; acc_first and acc_last are ignored.
- acc_first and acc_last on the same beat: single-beat result, psum_fwd = sext(dot).
- Beat without a preceding first (after reset): accumulates onto the current acc (0 after reset).
- acc_last followed by a non-first beat: accumulation continues from the emitted value.
- Width or sign change between beats is legal. Each beat is decoded with its own controls; the mixed sum accumulates as-is.
- The accumulator is a single register; no internal buffering beyond the 3 pipeline stages.

Test Plan:
- 8x8 unsigned: in=0x000000FF, weight=0x000000FF, first+last -> psum_valid 3 cycles later, psum_fwd=65025, acc_ovf=0.
- 8x8 signed: in=0x80, weight=0x7F, s_in=s_weight=1, first+last -> psum_fwd=-16256 (0xFFFFC080).
- 2x2 signed, 16 lanes: in=0xFFFFFFFF, weight=0x55555555, s_in=s_weight=1 -> psum_fwd=-16.
- Mixed 4x8 unsigned, P=2: in=0x37, weight=0x0A05 -> 7*5+3*10 = 65.
- Burst: four back-to-back 8x8 unsigned 255*255 beats (first on beat 1, last on beat 4), then a bubble, then a single 1*1 first+last beat:
  - psum_valid exactly twice.
  - Values 260100, then 1.
  - Assert reset during a second burst: no strobe, outputs 0.
- ACC_W=18: three 255*255 unsigned beats, first/last framing -> psum_fwd=-67069 (wrapped), acc_ovf=1.
  - A following first+last beat with value 1 -> psum_fwd=1, acc_ovf=0.
